mem_arbiter: RTL and testbench

//  - Shares one memory port between instruction fetch (IFU) and the load/store path (LSU).
//  - Sits between the core's PC/fetch logic, the data-memory access logic and the memory model.
//  - One transaction in flight at a time.
//  - LSU has priority; a starvation counter guarantees IFU forward progress.
//  - A response timeout returns an error instead of hanging the core.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 55 +++++
 rtl/arb_prio_starve.sv | 49 ++++
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter slice.
//   - FSM state encoding (IDLE / REQ / WAIT_RSP)
//   - transaction owner encoding (IFU / LSU)
//   - bus width constants used by the interface and the arbiter
// No ports: this file holds only types and constants.
package mem_arbiter_pkg;

  localparam int XLEN  = 32;
  localparam int MASKW = 4;

  // Width of the response timeout counter.
  localparam int TMO_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every handshake/bus signal around the memory arbiter.
//   ifu_*  : instruction-fetch request/response channel
//   lsu_*  : load/store request/response channel
//   mem_*  : the single shared memory port
// Modports:
//   slave  : the arbiter's view (takes IFU/LSU requests, drives memory)
//   master : the environment's view (fetch logic, LSU and memory model)
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic             ifu_req_valid;
  logic             ifu_req_ready;
  logic [XLEN-1:0]  ifu_addr;
  logic             ifu_rsp_valid;
  logic [XLEN-1:0]  ifu_rdata;
  logic             ifu_rsp_err;

  logic             lsu_req_valid;
  logic             lsu_req_ready;
  logic [XLEN-1:0]  lsu_addr;
  logic             lsu_wen;
  logic [XLEN-1:0]  lsu_wdata;
  logic [MASKW-1:0] lsu_wmask;
  logic             lsu_rsp_valid;
  logic [XLEN-1:0]  lsu_rdata;
  logic             lsu_rsp_err;

  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [XLEN-1:0]  mem_addr;
  logic             mem_wen;
  logic [XLEN-1:0]  mem_wdata;
  logic [MASKW-1:0] mem_wmask;
  logic             mem_rsp_valid;
  logic [XLEN-1:0]  mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata, ifu_rsp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_rsp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );

endinterface

// File: rtl/arb_prio_starve.sv
// Winner selection for the shared memory port with IFU starvation guard.
// LSU has priority, but after STARVE_LIMIT consecutive LSU grants taken
// while the IFU was waiting, the IFU is forced through once.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   ifu_req_valid  fetch request pending
//   lsu_req_valid  load/store request pending
//   in_idle        arbiter FSM is in IDLE (only then is a grant issued)
//   grant_ifu      IFU wins this cycle (combinational)
//   grant_lsu      LSU wins this cycle (combinational)
module arb_prio_starve #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ifu_req_valid,
  input  logic lsu_req_valid,
  input  logic in_idle,
  output logic grant_ifu,
  output logic grant_lsu
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          ifu_forced;

  always_comb begin
    ifu_forced = (starve_cnt == LIMIT) && ifu_req_valid;
    grant_lsu  = in_idle && lsu_req_valid && !ifu_forced;
    grant_ifu  = in_idle && ifu_req_valid && !grant_lsu;
  end

  // Requesters hold valid until ready, so a grant in IDLE is an accept.
  // An idle IFU or an IFU accept both restart the starvation window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (in_idle) begin
      if (!ifu_req_valid || grant_ifu) begin
        starve_cnt <= '0;
      end else if (grant_lsu && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (IFU) and the
// load/store unit (LSU), one transaction in flight at a time.
//   IDLE     : pick a winner, accept it combinationally, latch its payload
//   REQ      : present the latched request until the memory accepts it
//   WAIT_RSP : wait for the memory response or give up after TIMEOUT cycles
// Responses are registered and routed to the owner as a one-cycle pulse;
// a timeout answers with err=1 and rdata=0. Late or stray memory
// responses outside WAIT_RSP are ignored.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset (drops any in-flight transaction)
//   bus  mem_arbiter_if.slave: IFU, LSU and memory channels
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_if.slave    bus
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  logic              grant_ifu;
  logic              grant_lsu;
  logic              ifu_acc;
  logic              lsu_acc;
  logic              mem_hs;
  logic              rsp_hit;
  logic              rsp_tmo;
  logic [TMO_W-1:0]  tmo_cnt;

  owner_t            owner_p0;
  logic [XLEN-1:0]   addr_p0;
  logic              wen_p0;
  logic [XLEN-1:0]   wdata_p0;
  logic [MASKW-1:0]  wmask_p0;

  logic              ifu_vld_p1;
  logic              ifu_err_p1;
  logic [XLEN-1:0]   ifu_rdata_p1;
  logic              lsu_vld_p1;
  logic              lsu_err_p1;
  logic [XLEN-1:0]   lsu_rdata_p1;

  arb_prio_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (bus.ifu_req_valid),
    .lsu_req_valid (bus.lsu_req_valid),
    .in_idle       (state == IDLE),
    .grant_ifu     (grant_ifu),
    .grant_lsu     (grant_lsu)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ready is masked by rst so that every output reads 0 while reset is
  // held, even though the reset state IDLE would otherwise grant.
  always_comb begin
    state_nxt = state;
    ifu_acc   = 1'b0;
    lsu_acc   = 1'b0;
    mem_hs    = 1'b0;
    rsp_hit   = 1'b0;
    rsp_tmo   = 1'b0;
    case (state)
      IDLE: begin
        ifu_acc = grant_ifu && !rst;
        lsu_acc = grant_lsu && !rst;
        if (ifu_acc || lsu_acc) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_hs = bus.mem_req_ready;
        if (mem_hs) begin
          state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A real response wins over a timeout landing in the same cycle.
        rsp_hit = bus.mem_rsp_valid;
        rsp_tmo = !bus.mem_rsp_valid && (tmo_cnt == TMO_LAST);
        if (rsp_hit || rsp_tmo) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: request payload latched at accept, held through REQ ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_p0 <= OWN_IFU;
      addr_p0  <= '0;
      wen_p0   <= 1'b0;
      wdata_p0 <= '0;
      wmask_p0 <= '0;
    end else if (ifu_acc) begin
      owner_p0 <= OWN_IFU;
      addr_p0  <= bus.ifu_addr;
      wen_p0   <= 1'b0;
      wdata_p0 <= '0;
      wmask_p0 <= '0;
    end else if (lsu_acc) begin
      owner_p0 <= OWN_LSU;
      addr_p0  <= bus.lsu_addr;
      wen_p0   <= bus.lsu_wen;
      wdata_p0 <= bus.lsu_wdata;
      wmask_p0 <= bus.lsu_wmask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (mem_hs) begin
      tmo_cnt <= '0;
    end else if (state == WAIT_RSP) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // ---- stage p1: registered response routed to the owner ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifu_vld_p1   <= 1'b0;
      ifu_err_p1   <= 1'b0;
      ifu_rdata_p1 <= '0;
      lsu_vld_p1   <= 1'b0;
      lsu_err_p1   <= 1'b0;
      lsu_rdata_p1 <= '0;
    end else begin
      ifu_vld_p1 <= 1'b0;
      ifu_err_p1 <= 1'b0;
      lsu_vld_p1 <= 1'b0;
      lsu_err_p1 <= 1'b0;
      if (rsp_hit || rsp_tmo) begin
        if (owner_p0 == OWN_IFU) begin
          ifu_vld_p1   <= 1'b1;
          ifu_err_p1   <= rsp_tmo;
          ifu_rdata_p1 <= rsp_hit ? bus.mem_rdata : '0;
        end else begin
          lsu_vld_p1   <= 1'b1;
          lsu_err_p1   <= rsp_tmo;
          // Stores acknowledge with zero data regardless of the bus.
          lsu_rdata_p1 <= (rsp_hit && !wen_p0) ? bus.mem_rdata : '0;
        end
      end
    end
  end

  assign bus.ifu_req_ready = ifu_acc;
  assign bus.lsu_req_ready = lsu_acc;
  assign bus.mem_req_valid = (state == REQ);
  assign bus.mem_addr      = addr_p0;
  assign bus.mem_wen       = wen_p0;
  assign bus.mem_wdata     = wdata_p0;
  assign bus.mem_wmask     = wmask_p0;
  assign bus.ifu_rsp_valid = ifu_vld_p1;
  assign bus.ifu_rsp_err   = ifu_err_p1;
  assign bus.ifu_rdata     = ifu_rdata_p1;
  assign bus.lsu_rsp_valid = lsu_vld_p1;
  assign bus.lsu_rsp_err   = lsu_err_p1;
  assign bus.lsu_rdata     = lsu_rdata_p1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model, response scoreboard
// and one task per scenario.
module tb_mem_arbiter;

  typedef struct packed {
    logic        lsu;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } txn_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  exp_t sb[$];
  txn_t mlog[$];

  // memory model controls
  bit          silent;
  bit          late_req;
  int          stall_left;
  bit          pending;
  logic [31:0] pend_addr;
  logic        pend_wen;
  int          hs_cyc;

  int n_ifu_rsp;
  int n_lsu_rsp;
  int last_ifu_cyc;
  int last_lsu_cyc;

  mem_arbiter_if bus();

  mem_arbiter #(
    .STARVE_LIMIT (4),
    .TIMEOUT      (255)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    return (a == 32'h80000000) ? 32'h00100093 : (a ^ 32'hA5A55A5A);
  endfunction

  function automatic logic [139:0] outs();
    return {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_rsp_valid, bus.ifu_rsp_err,
            bus.ifu_rdata, bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.lsu_rdata,
            bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask};
  endfunction

  // Memory model: acts on negedges, answers one cycle after the handshake.
  initial begin
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'h0;
    forever begin
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      if (rst) begin
        pending = 1'b0;
        bus.mem_req_ready = 1'b1;
      end else begin
        if (late_req) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rdata     = 32'hBAD0BAD0;
          late_req          = 1'b0;
        end else if (pending) begin
          pending = 1'b0;
          if (!silent) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rdata     = pend_wen ? 32'h0F0F0F0F : model_rdata(pend_addr);
          end
        end
        if (bus.mem_req_valid && stall_left > 0) begin
          bus.mem_req_ready = 1'b0;
          stall_left--;
        end else begin
          bus.mem_req_ready = 1'b1;
        end
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          pending   = 1'b1;
          pend_addr = bus.mem_addr;
          pend_wen  = bus.mem_wen;
          hs_cyc    = cyc;
          mlog.push_back({bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask});
        end
      end
    end
  end

  // Scoreboard consumer: every response pulse pops and compares one entry.
  initial begin
    exp_t e;
    logic [34:0] obs;
    logic [34:0] req;
    forever begin
      @(negedge clk);
      if (!rst && (bus.ifu_rsp_valid || bus.lsu_rsp_valid)) begin
        if (bus.ifu_rsp_valid) begin n_ifu_rsp++; last_ifu_cyc = cyc; end
        if (bus.lsu_rsp_valid) begin n_lsu_rsp++; last_lsu_cyc = cyc; end
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected ifu_v=%0b lsu_v=%0b at cycle %0d, required no response",
                   bus.ifu_rsp_valid, bus.lsu_rsp_valid, cyc);
        end else begin
          e   = sb.pop_front();
          obs = e.lsu ? {bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.lsu_rdata}
                      : {bus.ifu_rsp_valid, bus.lsu_rsp_valid, bus.ifu_rsp_err, bus.ifu_rdata};
          req = {!e.lsu, e.lsu, e.err, e.rdata};
          if (obs !== req) begin
            failures++;
            $display("FAIL rsp_data got {ifu_v,lsu_v,err,rdata}=%h required %h", obs, req);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input bit lsu, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (lsu ? bus.lsu_req_ready : bus.ifu_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic issue_ifu(input logic [31:0] a, input logic tmo, output int acc);
    bit ok;
    bus.ifu_addr = a;
    bus.ifu_req_valid = 1'b1;
    wait_ready(1'b0, ok);
    acc = cyc;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ifu_accept no ifu_req_ready in 64 cycles, required accept of %h", a);
    end else begin
      sb.push_back({1'b0, tmo ? 32'h0 : model_rdata(a), tmo});
    end
    @(posedge clk);
    #1;
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr = 32'hDEAD0000;
  endtask

  task automatic issue_lsu(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input logic [3:0] wm, output int acc);
    bit ok;
    bus.lsu_addr = a; bus.lsu_wen = w; bus.lsu_wdata = wd; bus.lsu_wmask = wm;
    bus.lsu_req_valid = 1'b1;
    wait_ready(1'b1, ok);
    acc = cyc;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL lsu_accept no lsu_req_ready in 64 cycles, required accept of %h", a);
    end else begin
      sb.push_back({1'b1, w ? 32'h0 : model_rdata(a), 1'b0});
    end
    @(posedge clk);
    #1;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr = 32'hFFFFFFFF; bus.lsu_wdata = 32'h0; bus.lsu_wmask = 4'h0; bus.lsu_wen = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain %0d responses outstanding after 400 cycles, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (outs() !== 140'h0) begin
      failures++;
      $display("FAIL reset_outputs got %h required all zero", outs());
    end
    @(posedge clk); #1;
    bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 140'h0) begin
      failures++;
      $display("FAIL reset_idle got %h required all zero", outs());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_fetch();
    int acc, nl, nlog;
    nl = n_lsu_rsp; nlog = mlog.size();
    issue_ifu(32'h80000000, 1'b0, acc);
    @(negedge clk);
    checks++;
    if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask} !== {1'b1, 32'h80000000, 1'b0, 4'h0}) begin
      failures++;
      $display("FAIL fetch_mem_req got v=%0b addr=%h wen=%0b mask=%h required v=1 addr=80000000 wen=0 mask=0",
               bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask);
    end
    drain();
    checks++;
    if (last_ifu_cyc !== acc + 3) begin
      failures++;
      $display("FAIL fetch_latency rsp at cycle %0d required %0d", last_ifu_cyc, acc + 3);
    end
    checks++;
    if (n_lsu_rsp !== nl || mlog.size() !== nlog + 1) begin
      failures++;
      $display("FAIL fetch_side_effects lsu_rsp=%0d txns=%0d required lsu_rsp=%0d txns=%0d",
               n_lsu_rsp - nl, mlog.size() - nlog, 0, 1);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int start, lacc, iacc, nlog;
    txn_t t0, t1;
    nlog = mlog.size();
    bus.lsu_addr = 32'h80001000; bus.lsu_wen = 1'b1; bus.lsu_wdata = 32'hDEADBEEF; bus.lsu_wmask = 4'hF;
    bus.ifu_addr = 32'h80000004;
    bus.lsu_req_valid = 1'b1; bus.ifu_req_valid = 1'b1;
    start = cyc;
    wait_ready(1'b1, ok);
    lacc = cyc;
    checks++;
    if (!ok || lacc != start || bus.ifu_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL simul_lsu_first ok=%0b acc_cycle=%0d ifu_ready=%0b required ok=1 acc_cycle=%0d ifu_ready=0",
               ok, lacc, bus.ifu_req_ready, start);
    end
    if (ok) sb.push_back({1'b1, 32'h0, 1'b0});
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    wait_ready(1'b0, ok);
    iacc = cyc;
    if (ok) sb.push_back({1'b0, model_rdata(32'h80000004), 1'b0});
    checks++;
    if (!ok || iacc != lacc + 3) begin
      failures++;
      $display("FAIL simul_ifu_next ok=%0b ifu_acc_cycle=%0d required ok=1 cycle %0d", ok, iacc, lacc + 3);
    end
    @(posedge clk); #1;
    bus.ifu_req_valid = 1'b0;
    drain();
    checks++;
    if (mlog.size() != nlog + 2) begin
      failures++;
      $display("FAIL simul_txn_count got %0d required 2", mlog.size() - nlog);
    end else begin
      t0 = mlog[nlog]; t1 = mlog[nlog + 1];
      checks++;
      if (t0 !== {32'h80001000, 1'b1, 32'hDEADBEEF, 4'hF}) begin
        failures++;
        $display("FAIL simul_store_txn got %h required %h", t0, {32'h80001000, 1'b1, 32'hDEADBEEF, 4'hF});
      end
      checks++;
      if (t1 !== {32'h80000004, 1'b0, 32'h0, 4'h0}) begin
        failures++;
        $display("FAIL simul_fetch_txn got %h required %h", t1, {32'h80000004, 1'b0, 32'h0, 4'h0});
      end
    end
  endtask

  task automatic test_starvation();
    bit ok;
    logic [5:0] order;
    logic [31:0] la, ia;
    order = 6'b0; la = 32'h80003000; ia = 32'h80000400;
    bus.lsu_addr = la; bus.lsu_wen = 1'b0; bus.lsu_wdata = 32'h0; bus.lsu_wmask = 4'h0;
    bus.ifu_addr = ia;
    bus.lsu_req_valid = 1'b1; bus.ifu_req_valid = 1'b1;
    for (int g = 0; g < 6; g++) begin
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        if (bus.ifu_req_ready || bus.lsu_req_ready) begin ok = 1'b1; break; end
      end
      if (!ok) break;
      order = {order[4:0], bus.lsu_req_ready};
      if (bus.lsu_req_ready) sb.push_back({1'b1, model_rdata(la), 1'b0});
      else                   sb.push_back({1'b0, model_rdata(ia), 1'b0});
      @(posedge clk); #1;
      la = la + 4; ia = ia + 4;
      bus.lsu_addr = la; bus.ifu_addr = ia;
    end
    bus.lsu_req_valid = 1'b0; bus.ifu_req_valid = 1'b0;
    drain();
    checks++;
    if (!ok || order !== 6'b111101) begin
      failures++;
      $display("FAIL starve_order got %b (ok=%0b) required 111101 (1=LSU)", order, ok);
    end
  endtask

  task automatic test_backpressure();
    int acc, nlog;
    nlog = mlog.size();
    stall_left = 5;
    issue_lsu(32'h80002000, 1'b1, 32'h12345678, 4'b0110, acc);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask} !==
          {1'b1, 32'h80002000, 1'b1, 32'h12345678, 4'b0110}) begin
        failures++;
        $display("FAIL backpressure_hold cycle %0d got v=%0b addr=%h wdata=%h mask=%h required v=1 addr=80002000 wdata=12345678 mask=6",
                 i, bus.mem_req_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
      end
    end
    drain();
    checks++;
    if (mlog.size() != nlog + 1) begin
      failures++;
      $display("FAIL backpressure_txns got %0d required 1", mlog.size() - nlog);
    end
  endtask

  task automatic test_timeout();
    int acc, gap, nrsp;
    silent = 1'b1;
    issue_ifu(32'h80000100, 1'b1, acc);
    drain();
    gap = last_ifu_cyc - hs_cyc;
    checks++;
    if (gap < 256 || gap > 258) begin
      failures++;
      $display("FAIL timeout_delay rsp %0d cycles after handshake, required about 257", gap);
    end
    silent = 1'b0;
    nrsp = n_ifu_rsp + n_lsu_rsp;
    late_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (n_ifu_rsp + n_lsu_rsp != nrsp || bus.mem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL late_rsp_ignored extra_rsp=%0d mem_req_valid=%0b required 0 and 0",
               n_ifu_rsp + n_lsu_rsp - nrsp, bus.mem_req_valid);
    end
    issue_ifu(32'h80000104, 1'b0, acc);
    drain();
  endtask

  task automatic test_reset_mid();
    int acc;
    silent = 1'b1;
    issue_ifu(32'h80000200, 1'b1, acc);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1;
    #1;
    checks++;
    if (outs() !== 140'h0) begin
      failures++;
      $display("FAIL reset_mid_outputs got %h required all zero", outs());
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    bus.ifu_req_valid = 1'b0; bus.lsu_req_valid = 1'b0;
    silent = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    issue_ifu(32'h80000000, 1'b0, acc);
    drain();
    checks++;
    if (last_ifu_cyc !== acc + 3) begin
      failures++;
      $display("FAIL reset_mid_refetch rsp at cycle %0d required %0d", last_ifu_cyc, acc + 3);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    silent = 1'b0; late_req = 1'b0; stall_left = 0; pending = 1'b0; hs_cyc = 0;
    n_ifu_rsp = 0; n_lsu_rsp = 0; last_ifu_cyc = -1; last_lsu_cyc = -1;
    bus.ifu_req_valid = 1'b0; bus.ifu_addr = 32'h0;
    bus.lsu_req_valid = 1'b0; bus.lsu_addr = 32'h0; bus.lsu_wen = 1'b0;
    bus.lsu_wdata = 32'h0; bus.lsu_wmask = 4'h0;
    rst = 1'b1;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_empty %0d entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
